multi_pwm_breather: RTL and testbench
=====================================

MULTI_PWM_BREATHER -- requirements
Module: multi_pwm_breather

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent PWM channels, legal range 1..16.
REQ-002 Parameter PWM_W, default 8: PWM counter, level and duty width in bits, legal range 4..12.
REQ-003 Parameter DIV_W, default 16: width of the ramp prescaler and of step_div.
REQ-004 Port clk, input, 1 bit: 12 MHz system clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port en, input, 1 bit: run enable; when low, counters and ramps hold.
REQ-007 Port mode, input, 1 bit: 0 = sawtooth ramp, 1 = triangle ("breathing") ramp.
REQ-008 Port step_div, input, DIV_W bits: number of extra PWM periods between ramp steps.
REQ-009 Port pwm_out, output, NUM_CH bits: registered PWM outputs, one bit per channel.
REQ-010 Port period_tick, output, 1 bit: registered one-cycle pulse at each PWM period wrap.

Function
REQ-011 pwm_cnt (PWM_W bits) SHALL increment by 1 each cycle en=1, wrapping 2^PWM_W-1 -> 0; it SHALL hold when en=0.
REQ-012 A wrap SHALL be the cycle with en=1 and pwm_cnt=2^PWM_W-1; period_tick SHALL be 1 on the following cycle only.
REQ-013 Prescaler presc (DIV_W bits) SHALL advance on each wrap; on a wrap with presc==step_div it SHALL clear to 0 and issue one ramp step.
REQ-014 step_div=0 SHALL give one ramp step per PWM period; step_div=N SHALL give one step every N+1 periods.
REQ-015 A step_div change SHALL be compared at the next wrap; if presc>step_div, presc SHALL continue counting up to its all-ones value, wrap to 0, and continue counting up to step_div before stepping.
REQ-016 Each channel k SHALL hold level[k] (PWM_W bits) and dir[k] (1 = up).
REQ-017 Triangle mode: on a step, a channel with dir=1 SHALL increment level; if level==2^PWM_W-1, it SHALL instead clear dir with level unchanged.
REQ-018 Triangle mode: on a step, a channel with dir=0 SHALL decrement level; if level==0, it SHALL instead set dir with level unchanged.
REQ-019 Each triangle endpoint SHALL therefore persist for two step intervals, and the full triangle period SHALL be 2^(PWM_W+1) steps.
REQ-020 Sawtooth mode: on a step, level SHALL increment, wrapping 2^PWM_W-1 -> 0, and dir SHALL be forced to 1.
REQ-021 A mode change SHALL take effect at the next ramp step; level SHALL not jump.
REQ-022 Duty shadow duty_q[k] SHALL load from the corrected level (see Configuration) only on a wrap cycle, so that duty never changes mid-period.
REQ-023 pwm_out[k] SHALL be registered as (pwm_cnt < duty_q[k]) when en=1; duty 0 SHALL give constant low, and duty 2^PWM_W-1 SHALL give high for 2^PWM_W-1 of 2^PWM_W cycles.
REQ-024 When en=0, pwm_out SHALL be 0 from the next cycle; on re-enable, operation SHALL resume from the held counter values.
REQ-025 A wrap coinciding with a ramp step SHALL load duty_q from the pre-step level, so the new level appears one period later.

Reset
REQ-026 While rst=1: pwm_cnt, presc, duty_q, pwm_out and period_tick SHALL be 0.
REQ-027 While rst=1: dir[k]=1 and level[k]=(k*2^PWM_W)/NUM_CH, truncated, giving evenly spread phase offsets.
REQ-028 Reset asserted mid-period or mid-ramp SHALL abort immediately; the first wrap after release SHALL occur 2^PWM_W cycles after the first en=1 cycle.

Configuration
REQ-029 Macro BREATHE_GAMMA_EN, when defined, SHALL make the corrected level (level*level)>>PWM_W, computed at full 2*PWM_W-bit precision for perceptual linearity.
REQ-030 When BREATHE_GAMMA_EN is undefined, the corrected level SHALL equal level, and no multiplier logic SHALL be synthesised.

Verification
REQ-031 NUM_CH=2, PWM_W=8, reset release with en=1: period_tick pulses every 256 cycles; initial levels are 0 and 128; pwm_out[1] is high for 128 of 256 cycles after the first wrap.
REQ-032 mode=1, step_div=0: level[0] ramps 0..255, holds 255 for two steps, descends to 0, holds; the first return to 0 occurs after 511 steps from reset release, and the full triangle period is 512 steps.
REQ-033 mode=0, step_div=3: a ramp step occurs every 4 periods (1024 cycles); level[0] wraps 255 -> 0 after 256 steps.
REQ-034 en dropped for 100 cycles mid-period: pwm_out goes to 0 on the next cycle, pwm_cnt and levels are unchanged, and the period resumes seamlessly.
REQ-035 rst pulsed mid-ramp at level 77: all outputs are 0 immediately, and levels return to 0 and 128.
REQ-036 BREATHE_GAMMA_EN defined with level 128: duty_q=64; with the macro undefined: duty_q=128.

Source files
------------

// File: rtl/multi_pwm_breather.sv
// -----------------------------------------------------------------------------
// multi_pwm_breather
//
// Purpose:
//   Multi-channel LED "breathing" PWM generator. A shared free-running PWM
//   counter defines the PWM period. A prescaler counts periods and issues ramp
//   steps. Each channel owns a ramp level. The ramp is either a sawtooth or a
//   triangle, and each channel starts from its own phase offset. The level is
//   copied into a per-channel duty shadow only at a period wrap, so the duty
//   never changes part-way through a period.
//
// Parameters:
//   NUM_CH  number of channels (1..16)
//   PWM_W   width of the PWM counter, levels and duty (4..12)
//   DIV_W   width of the ramp prescaler and of step_div
//
// Ports:
//   clk          system clock; all state updates on its rising edge
//   rst          asynchronous, active-high reset
//   en           run enable; when low the counter, prescaler and ramps hold
//                and pwm_out is forced low
//   mode         0 = sawtooth ramp, 1 = triangle ramp
//   step_div     number of extra PWM periods between ramp steps
//   pwm_out      registered PWM output, one bit per channel
//   period_tick  registered one-cycle pulse following each PWM period wrap
//
// Build option:
//   BREATHE_GAMMA_EN  when defined, the duty is (level*level) >> PWM_W,
//                     computed at full 2*PWM_W precision. When undefined,
//                     the duty equals the level and no multiplier is built.
// -----------------------------------------------------------------------------
module multi_pwm_breather #(
  parameter int NUM_CH = 2,
  parameter int PWM_W  = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic [DIV_W-1:0]  step_div,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick
);

  localparam logic [PWM_W-1:0] LVL_ZERO   = {PWM_W{1'b0}};
  localparam logic [PWM_W-1:0] LVL_ONE    = {{(PWM_W-1){1'b0}}, 1'b1};
  localparam logic [PWM_W-1:0] LVL_MAX    = {PWM_W{1'b1}};
  localparam logic [DIV_W-1:0] PRESC_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] PRESC_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  // Reset level of channel k: (k * 2^PWM_W) / NUM_CH, truncated. This
  // spreads the channels evenly around the ramp.
  function automatic logic [PWM_W-1:0] init_level(input int k);
    int full_s;
    full_s = (k << PWM_W) / NUM_CH;
    return full_s[PWM_W-1:0];
  endfunction

  // Maps a ramp level to the duty that is loaded into the shadow register.
  function automatic logic [PWM_W-1:0] correct_level(input logic [PWM_W-1:0] lvl);
`ifdef BREATHE_GAMMA_EN
    logic [2*PWM_W-1:0] sq_s;
    sq_s = {{PWM_W{1'b0}}, lvl} * {{PWM_W{1'b0}}, lvl};
    return sq_s[2*PWM_W-1:PWM_W];
`else
    return lvl;
`endif
  endfunction

  logic [PWM_W-1:0]             pwm_cnt_r;
  logic [DIV_W-1:0]             presc_r;
  logic                         period_tick_r;
  logic [NUM_CH-1:0]            pwm_out_r;
  logic [NUM_CH-1:0][PWM_W-1:0] level_r;
  logic [NUM_CH-1:0]            dir_r;
  logic [NUM_CH-1:0][PWM_W-1:0] duty_r;

  logic                         wrap_s;
  logic                         step_s;
  logic [NUM_CH-1:0][PWM_W-1:0] level_nxt_s;
  logic [NUM_CH-1:0]            dir_nxt_s;
  logic [NUM_CH-1:0][PWM_W-1:0] corr_s;
  logic [NUM_CH-1:0]            pwm_nxt_s;

  // A wrap is the last enabled cycle of a period. A ramp step happens on a
  // wrap only when the prescaler has reached step_div exactly. If step_div
  // drops below the current prescaler value, the prescaler keeps counting,
  // rolls over through zero and then matches the new value.
  always_comb begin
    wrap_s = en & (pwm_cnt_r == LVL_MAX);
    step_s = wrap_s & (presc_r == step_div);
  end

  // Next ramp position of every channel, applied only when a step occurs.
  always_comb begin
    level_nxt_s = level_r;
    dir_nxt_s   = dir_r;
    for (int k = 0; k < NUM_CH; k++) begin
      if (mode) begin
        // Triangle ramp: an endpoint spends one step turning around, so the
        // level stays at the top and bottom for two step intervals.
        if (dir_r[k]) begin
          if (level_r[k] == LVL_MAX) begin
            level_nxt_s[k] = level_r[k];
            dir_nxt_s[k]   = 1'b0;
          end else begin
            level_nxt_s[k] = level_r[k] + LVL_ONE;
            dir_nxt_s[k]   = 1'b1;
          end
        end else begin
          if (level_r[k] == LVL_ZERO) begin
            level_nxt_s[k] = level_r[k];
            dir_nxt_s[k]   = 1'b1;
          end else begin
            level_nxt_s[k] = level_r[k] - LVL_ONE;
            dir_nxt_s[k]   = 1'b0;
          end
        end
      end else begin
        // Sawtooth ramp: the level wraps naturally at the counter width, and
        // the direction is kept "up" so a later switch to triangle rises first.
        level_nxt_s[k] = level_r[k] + LVL_ONE;
        dir_nxt_s[k]   = 1'b1;
      end
    end
  end

  // Duty source for the shadow registers and the next PWM output value.
  always_comb begin
    corr_s    = level_r;
    pwm_nxt_s = {NUM_CH{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      corr_s[k] = correct_level(level_r[k]);
      if (en) begin
        pwm_nxt_s[k] = (pwm_cnt_r < duty_r[k]);
      end else begin
        pwm_nxt_s[k] = 1'b0;
      end
    end
  end

  // PWM counter, period tick and ramp prescaler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_r     <= LVL_ZERO;
      presc_r       <= PRESC_ZERO;
      period_tick_r <= 1'b0;
    end else begin
      period_tick_r <= wrap_s;
      if (en) begin
        pwm_cnt_r <= pwm_cnt_r + LVL_ONE;
      end
      if (wrap_s) begin
        if (step_s) begin
          presc_r <= PRESC_ZERO;
        end else begin
          presc_r <= presc_r + PRESC_ONE;
        end
      end
    end
  end

  // Per-channel ramp level and direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        level_r[k] <= init_level(k);
        dir_r[k]   <= 1'b1;
      end
    end else if (step_s) begin
      level_r <= level_nxt_s;
      dir_r   <= dir_nxt_s;
    end
  end

  // Duty shadows and registered PWM outputs. The shadow loads on the wrap
  // edge from the level as it was before a step on that same edge, so a new
  // level is first seen in the period after next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_r    <= {(NUM_CH*PWM_W){1'b0}};
      pwm_out_r <= {NUM_CH{1'b0}};
    end else begin
      if (wrap_s) begin
        duty_r <= corr_s;
      end
      pwm_out_r <= pwm_nxt_s;
    end
  end

  assign pwm_out     = pwm_out_r;
  assign period_tick = period_tick_r;

endmodule

// File: tb/tb_multi_pwm_breather.sv
// -----------------------------------------------------------------------------
// tb_multi_pwm_breather
//
// Two instances share one clock:
//   u_big   NUM_CH=2, PWM_W=8, DIV_W=16  (default geometry)
//   u_small NUM_CH=3, PWM_W=4, DIV_W=4   (short periods, so full ramps,
//                                        rollovers and prescaler wrap fit)
// For each PWM period, the stimulus pushes the expected period length and
// per-channel high-cycle counts into a queue. A monitor per instance
// accumulates pwm_out between period_tick pulses and compares the totals
// against the queue at each tick.
// -----------------------------------------------------------------------------
module tb_multi_pwm_breather;

  typedef struct {
    int len;
    int d0;
    int d1;
    int d2;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b, en_b, mode_b;
  logic [15:0] div_b;
  logic [1:0]  pwm_b;
  logic        tick_b;

  logic        rst_s, en_s, mode_s;
  logic [3:0]  div_s;
  logic [2:0]  pwm_s;
  logic        tick_s;

  multi_pwm_breather #(.NUM_CH(2), .PWM_W(8), .DIV_W(16)) u_big (
    .clk(clk), .rst(rst_b), .en(en_b), .mode(mode_b), .step_div(div_b),
    .pwm_out(pwm_b), .period_tick(tick_b)
  );

  multi_pwm_breather #(.NUM_CH(3), .PWM_W(4), .DIV_W(4)) u_small (
    .clk(clk), .rst(rst_s), .en(en_s), .mode(mode_s), .step_div(div_s),
    .pwm_out(pwm_s), .period_tick(tick_s)
  );

  int n_eval = 0;
  int n_fail = 0;
  exp_t q_b[$];
  exp_t q_s[$];

  task automatic check(input string name, input int act, input int req);
    n_eval++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Duty seen on the pins for a given ramp level.
  function automatic int corr(input int lvl, input int w);
    int gamma_on;
`ifdef BREATHE_GAMMA_EN
    gamma_on = 1;
`else
    gamma_on = 0;
`endif
    return (gamma_on != 0) ? ((lvl * lvl) >> w) : lvl;
  endfunction

  // Triangle level after s steps, starting at init and rising. Position q runs
  // over 2^(w+1) slots: the first half rises, the second half mirrors it.
  function automatic int tri_lvl(input int init, input int s, input int w);
    int top;
    int q;
    top = 1 << w;
    q = (init + s) % (2 * top);
    return (q < top) ? q : (2 * top - 1 - q);
  endfunction

  // Steps taken before wrap w when step_div is changed from 6 to 2 after wrap 5:
  // the prescaler rolls over at 15 and the first step lands on wrap 19.
  function automatic int s3_steps(input int w);
    return (w <= 19) ? 0 : ((w - 20) / 3 + 1);
  endfunction

  // Waits, with a cycle budget, until n period ticks have been seen.
  task automatic wait_ticks(input bit big, input int n);
    int seen;
    int cycles;
    seen = 0;
    cycles = 0;
    while (seen < n && cycles < n * 400 + 400) begin
      @(negedge clk);
      cycles++;
      if (big ? tick_b : tick_s) seen++;
    end
    check(big ? "big_tick_wait" : "small_tick_wait", seen, n);
  endtask

  // Big-instance monitor.
  int   len_b, acc_b0, acc_b1;
  exp_t e_b;
  initial begin
    len_b = 0; acc_b0 = 0; acc_b1 = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_b) begin
        len_b = 0; acc_b0 = 0; acc_b1 = 0;
      end else begin
        len_b++;
        acc_b0 += pwm_b[0] ? 1 : 0;
        acc_b1 += pwm_b[1] ? 1 : 0;
        if (tick_b) begin
          if (q_b.size() == 0) begin
            check("big_unexpected_tick", 1, 0);
          end else begin
            e_b = q_b.pop_front();
            check("big_period_len", len_b, e_b.len);
            check("big_duty_ch0", acc_b0, e_b.d0);
            check("big_duty_ch1", acc_b1, e_b.d1);
          end
          len_b = 0; acc_b0 = 0; acc_b1 = 0;
        end
      end
    end
  end

  // Small-instance monitor.
  int   len_s, acc_s0, acc_s1, acc_s2;
  exp_t e_s;
  initial begin
    len_s = 0; acc_s0 = 0; acc_s1 = 0; acc_s2 = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_s) begin
        len_s = 0; acc_s0 = 0; acc_s1 = 0; acc_s2 = 0;
      end else begin
        len_s++;
        acc_s0 += pwm_s[0] ? 1 : 0;
        acc_s1 += pwm_s[1] ? 1 : 0;
        acc_s2 += pwm_s[2] ? 1 : 0;
        if (tick_s) begin
          if (q_s.size() == 0) begin
            check("small_unexpected_tick", 1, 0);
          end else begin
            e_s = q_s.pop_front();
            check("small_period_len", len_s, e_s.len);
            check("small_duty_ch0", acc_s0, e_s.d0);
            check("small_duty_ch1", acc_s1, e_s.d1);
            check("small_duty_ch2", acc_s2, e_s.d2);
          end
          len_s = 0; acc_s0 = 0; acc_s1 = 0; acc_s2 = 0;
        end
      end
    end
  end

  // Stimulus.
  initial begin
    exp_t e;
    int   k;
    int   inits [3];
    int   lv [3];
    inits[0] = 0; inits[1] = 5; inits[2] = 10;

    rst_b = 1'b1; en_b = 1'b1; mode_b = 1'b0; div_b = 16'd0;
    rst_s = 1'b1; en_s = 1'b1; mode_s = 1'b0; div_s = 4'd0;
    repeat (3) @(negedge clk);
    check("big_rst_pwm", int'(pwm_b), 0);
    check("big_rst_tick", int'(tick_b), 0);
    check("small_rst_pwm", int'(pwm_s), 0);
    check("small_rst_tick", int'(tick_s), 0);

    // Big: sawtooth, one step per period. Duty scored at tick m was loaded at
    // wrap m-1, i.e. the level after m-2 steps. Levels start at 0 and 128.
    // Period 6 contains a 100-cycle enable pause.
    for (int m = 1; m <= 77; m++) begin
      e.len = (m == 6) ? 356 : 256;
      e.d0  = (m == 1) ? 0 : corr((m - 2) % 256, 8);
      e.d1  = (m == 1) ? 0 : corr((128 + m - 2) % 256, 8);
      e.d2  = 0;
      q_b.push_back(e);
    end
    rst_b = 1'b0;
    wait_ticks(1'b1, 5);
    repeat (20) @(negedge clk);
    check("big_pwm1_before_pause", int'(pwm_b[1]), 1);
    en_b = 1'b0;
    @(posedge clk);
    #1;
    check("big_pwm_off_after_en_low", int'(pwm_b), 0);
    repeat (100) @(negedge clk);
    en_b = 1'b1;
    wait_ticks(1'b1, 72);
    // Ramp now at level 77 (duty 76 this period); both outputs high early on.
    repeat (10) @(negedge clk);
    check("big_pwm_before_rst", int'(pwm_b), 3);
    rst_b = 1'b1;
    #1;
    check("big_pwm_in_rst", int'(pwm_b), 0);
    check("big_tick_in_rst", int'(tick_b), 0);
    check("big_queue_drained", q_b.size(), 0);
    repeat (3) @(negedge clk);
    // After reset the levels are back at 0 and 128.
    e.len = 256; e.d0 = 0;          e.d1 = 0;            e.d2 = 0; q_b.push_back(e);
    e.len = 256; e.d0 = 0;          e.d1 = corr(128, 8); e.d2 = 0; q_b.push_back(e);
    e.len = 256; e.d0 = corr(1, 8); e.d1 = corr(129, 8); e.d2 = 0; q_b.push_back(e);
    rst_b = 1'b0;
    wait_ticks(1'b1, 3);
    check("big_queue_drained_2", q_b.size(), 0);
    rst_b = 1'b1;

    // Small S1: triangle, one step per period, switched to sawtooth after
    // tick 40 (so steps 41 onward are sawtooth). Levels start at 0, 5, 10.
    mode_s = 1'b1;
    div_s  = 4'd0;
    for (int m = 1; m <= 48; m++) begin
      k = m - 2;
      for (int c = 0; c < 3; c++) begin
        if (m == 1) lv[c] = 0;
        else if (k <= 40) lv[c] = corr(tri_lvl(inits[c], k, 4), 4);
        else lv[c] = corr((tri_lvl(inits[c], 40, 4) + k - 40) % 16, 4);
      end
      e.len = 16; e.d0 = lv[0]; e.d1 = lv[1]; e.d2 = lv[2];
      q_s.push_back(e);
    end
    @(negedge clk);
    rst_s = 1'b0;
    wait_ticks(1'b0, 40);
    mode_s = 1'b0;
    wait_ticks(1'b0, 8);
    check("small_s1_queue_drained", q_s.size(), 0);

    // Small S2: sawtooth, step_div=3: steps on wraps 4, 8, 12, ...
    rst_s = 1'b1;
    mode_s = 1'b0;
    div_s  = 4'd3;
    repeat (2) @(negedge clk);
    for (int m = 1; m <= 72; m++) begin
      k = (m - 2) / 4;
      for (int c = 0; c < 3; c++) begin
        lv[c] = (m == 1) ? 0 : corr((inits[c] + k) % 16, 4);
      end
      e.len = 16; e.d0 = lv[0]; e.d1 = lv[1]; e.d2 = lv[2];
      q_s.push_back(e);
    end
    rst_s = 1'b0;
    wait_ticks(1'b0, 72);
    check("small_s2_queue_drained", q_s.size(), 0);

    // Small S3: step_div lowered from 6 to 2 while the prescaler is at 5.
    rst_s = 1'b1;
    div_s = 4'd6;
    repeat (2) @(negedge clk);
    for (int m = 1; m <= 28; m++) begin
      k = s3_steps(m - 1);
      for (int c = 0; c < 3; c++) begin
        lv[c] = (m == 1) ? 0 : corr((inits[c] + k) % 16, 4);
      end
      e.len = 16; e.d0 = lv[0]; e.d1 = lv[1]; e.d2 = lv[2];
      q_s.push_back(e);
    end
    rst_s = 1'b0;
    wait_ticks(1'b0, 5);
    div_s = 4'd2;
    wait_ticks(1'b0, 23);
    check("small_s3_queue_drained", q_s.size(), 0);
    rst_s = 1'b1;

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
